flash_loader: RTL and testbench
===============================

FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter SRC_BASE, default 32'h1E00_0000, flash byte address of first halfword.
REQ-002 SHALL have parameter DST_BASE, default 32'h0000_0000, RAM byte address of first word.
REQ-003 SHALL have parameter WORD_COUNT, default 16'd1024, number of 32-bit words to copy, range 0..65535.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  level; sampled only in IDLE.
REQ-007 SHALL have ports busy  out  1  and done  out  1  (done sticky until next start).
REQ-008 SHALL have ports flash_addr_o  out  32, flash_select_o  out  1, flash_we_o  out  1, flash_data_i  in  32 (bits 15:0 valid), flash_ack_i  in  1.
REQ-009 SHALL have ports ram_addr_o  out  32, ram_data_o  out  32, ram_select_o  out  1, ram_we_o  out  1, ram_ack_i  in  1.
REQ-010 SHALL have port checksum_o  out  32  running word sum (see Configuration).

Function
REQ-011 SHALL implement states IDLE, RD_LO, RD_HI, WR, FIN.
REQ-012 IDLE: start=1 -> clear word index, clear checksum, done=0; go to FIN if WORD_COUNT=0, else RD_LO.
REQ-013 Halfword h of word i SHALL be read at flash_addr_o = SRC_BASE + ((2*i+h) << 2); h=0 in RD_LO, h=1 in RD_HI.
REQ-014 RD_LO/RD_HI: flash_select_o=1, flash_we_o=0 held until flash_ack_i=1; flash_data_i[15:0] latched on the ack cycle.
REQ-015 After every ack, the corresponding select SHALL be 0 for exactly one cycle before the next transaction is issued.
REQ-016 Word assembly SHALL be little-endian: ram_data_o = {high halfword, low halfword}.
REQ-017 WR: ram_addr_o = DST_BASE + (i << 2), ram_we_o=1, ram_select_o=1 held until ram_ack_i=1.
REQ-018 On WR ack: i increments; i = WORD_COUNT -> FIN, else RD_LO.
REQ-019 FIN: done=1 for all cycles from entry until next accepted start; busy=0; -> IDLE next cycle.
REQ-020 busy SHALL be 1 in RD_LO, RD_HI and WR only.
REQ-021 start while busy=1 SHALL be ignored; acks arriving while the matching select=0 SHALL be ignored.
REQ-022 Address arithmetic SHALL be modulo 2^32; word index SHALL be 17 bits so WORD_COUNT=65535 terminates.
REQ-023 Outputs SHALL be registered; no combinational path from any *_ack_i to any output.
REQ-024 Bus addresses SHALL be 0 whenever the corresponding select is 0.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, all outputs 0, index and checksum 0, regardless of state.
REQ-026 Reset mid-transfer SHALL abort without completing the pending bus cycle; RAM contents already written are retained.
REQ-027 First start is accepted no earlier than the first rising edge after rst deasserts.

Configuration
REQ-028 Macro FLASH_LOADER_CHECKSUM_EN defined: checksum_o = 32-bit wrap-around sum of every word written, updated on each WR ack, held after FIN.
REQ-029 Macro FLASH_LOADER_CHECKSUM_EN undefined: no accumulator logic; checksum_o tied to 0.

Verification
REQ-030 WORD_COUNT=2, flash halfwords 0x1111,0x2222,0x3333,0x4444, ack 1 cycle after select -> RAM[DST_BASE]=0x22221111, RAM[DST_BASE+4]=0x44443333, done=1, checksum_o=0x66664444 (with macro).
REQ-031 WORD_COUNT=0, start pulse -> busy stays 0, done=1 the cycle after start, no select asserted.
REQ-032 Flash ack delayed 5 cycles, RAM ack delayed 3 -> select held through delay, deasserted exactly 1 cycle after each ack, addresses 0x1E000000, 0x1E000004 in order.
REQ-033 rst=0 asserted while in RD_HI of word 3 -> all outputs 0 asynchronously; after rst=1 and new start, copy restarts from word 0.
REQ-034 start held high for whole transfer -> exactly one copy until FIN, then new copy restarts; stray ram_ack_i while ram_select_o=0 -> no index change.
REQ-035 Macro undefined, same stimulus as REQ-030 -> identical RAM contents, checksum_o=0.

Source files
------------

// File: rtl/flash_loader_if.sv
// ============================================================================
// flash_loader_if : flash read bus and RAM write bus used by flash_loader.
// Rev 1.0
// ============================================================================
`default_nettype none

interface flash_loader_if;
   logic [31:0] flash_addr_o;
   logic        flash_select_o;
   logic        flash_we_o;
   logic [31:0] flash_data_i;
   logic        flash_ack_i;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic        ram_select_o;
   logic        ram_we_o;
   logic        ram_ack_i;

   modport master (
      output flash_addr_o, flash_select_o, flash_we_o,
      input  flash_data_i, flash_ack_i,
      output ram_addr_o, ram_data_o, ram_select_o, ram_we_o,
      input  ram_ack_i
   );

   modport slave (
      input  flash_addr_o, flash_select_o, flash_we_o,
      output flash_data_i, flash_ack_i,
      input  ram_addr_o, ram_data_o, ram_select_o, ram_we_o,
      output ram_ack_i
   );
endinterface

`default_nettype wire

// File: rtl/flash_loader.sv
// ============================================================================
// flash_loader : copies WORD_COUNT words from 16-bit flash into 32-bit RAM.
// Optional macro FLASH_LOADER_CHECKSUM_EN adds a running word-sum checksum.
// Rev 1.0
// ============================================================================
`default_nettype none

module flash_loader #(
   parameter logic [31:0] SRC_BASE   = 32'h1E00_0000,
   parameter logic [31:0] DST_BASE   = 32'h0000_0000,
   parameter logic [15:0] WORD_COUNT = 16'd1024
) (
   input  wire         clk,
   input  wire         rst,
   input  wire         start,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum_o,
   flash_loader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_LO = 3'd1,
      S_RD_HI = 3'd2,
      S_WR    = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t      r_state, w_state;
   logic [16:0] r_idx, w_idx;
   logic [16:0] w_idx_inc;
   logic [15:0] r_lo, w_lo;
   logic        r_fsel, w_fsel;
   logic [31:0] r_faddr, w_faddr;
   logic        r_rsel, w_rsel;
   logic [31:0] r_raddr, w_raddr;
   logic [31:0] r_rdata, w_rdata;
   logic        r_busy, w_busy;
   logic        r_done, w_done;
   logic        w_unused_hi;

   assign w_idx_inc   = r_idx + 17'd1;
   assign w_unused_hi = ^bus.flash_data_i[31:16];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_lo    <= '0;
         r_fsel  <= 1'b0;
         r_faddr <= '0;
         r_rsel  <= 1'b0;
         r_raddr <= '0;
         r_rdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_lo    <= w_lo;
         r_fsel  <= w_fsel;
         r_faddr <= w_faddr;
         r_rsel  <= w_rsel;
         r_raddr <= w_raddr;
         r_rdata <= w_rdata;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   // Each bus state enters with its select low, raises it on the next cycle and
   // drops it on the ack cycle, so a select is always low for one cycle between
   // transactions and acks seen while the select is low fall through untouched.
   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_lo    = r_lo;
      w_fsel  = r_fsel;
      w_faddr = r_faddr;
      w_rsel  = r_rsel;
      w_raddr = r_raddr;
      w_rdata = r_rdata;
      w_done  = r_done;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_idx   = '0;
               w_done  = 1'b0;
               w_state = (WORD_COUNT == 16'd0) ? S_FIN : S_RD_LO;
            end
         end
         S_RD_LO: begin
            if (!r_fsel) begin
               w_fsel  = 1'b1;
               w_faddr = SRC_BASE + {12'd0, r_idx, 1'b0, 2'b00};
            end else if (bus.flash_ack_i) begin
               w_fsel  = 1'b0;
               w_faddr = '0;
               w_lo    = bus.flash_data_i[15:0];
               w_state = S_RD_HI;
            end
         end
         S_RD_HI: begin
            if (!r_fsel) begin
               w_fsel  = 1'b1;
               w_faddr = SRC_BASE + {12'd0, r_idx, 1'b1, 2'b00};
            end else if (bus.flash_ack_i) begin
               w_fsel  = 1'b0;
               w_faddr = '0;
               w_rdata = {bus.flash_data_i[15:0], r_lo};
               w_state = S_WR;
            end
         end
         S_WR: begin
            if (!r_rsel) begin
               w_rsel  = 1'b1;
               w_raddr = DST_BASE + {13'd0, r_idx, 2'b00};
            end else if (bus.ram_ack_i) begin
               w_rsel  = 1'b0;
               w_raddr = '0;
               w_idx   = w_idx_inc;
               w_state = (w_idx_inc == {1'b0, WORD_COUNT}) ? S_FIN : S_RD_LO;
            end
         end
         S_FIN: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      if (w_state == S_FIN) begin
         w_done = 1'b1;
      end
      w_busy = (w_state == S_RD_LO) || (w_state == S_RD_HI) || (w_state == S_WR);
   end

`ifdef FLASH_LOADER_CHECKSUM_EN
   logic [31:0] r_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sum <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_sum <= '0;
      end else if ((r_state == S_WR) && r_rsel && bus.ram_ack_i) begin
         r_sum <= r_sum + r_rdata;
      end
   end

   assign checksum_o = r_sum;
`else
   assign checksum_o = 32'd0;
`endif

   assign busy               = r_busy;
   assign done               = r_done;
   assign bus.flash_addr_o   = r_faddr;
   assign bus.flash_select_o = r_fsel;
   assign bus.flash_we_o     = 1'b0;
   assign bus.ram_addr_o     = r_raddr;
   assign bus.ram_data_o     = r_rdata;
   assign bus.ram_select_o   = r_rsel;
   assign bus.ram_we_o       = r_rsel;

endmodule

`default_nettype wire

// File: tb/tb_flash_loader.sv
// ============================================================================
// tb_flash_loader : directed, table-driven bench for flash_loader.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_flash_loader;

   localparam logic [31:0] SRC = 32'h1E00_0000;
   localparam logic [31:0] DST = 32'h0000_0100;

   typedef struct {
      int                fd;
      int                rd;
      logic [7:0][15:0]  hw;
      logic [3:0][31:0]  w;
      logic [31:0]       sum;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        start_z = 1'b0;
   logic        busy, done, busy_z, done_z;
   logic [31:0] csum, csum_z;

   flash_loader_if bus ();
   flash_loader_if bus_z ();

   flash_loader #(.SRC_BASE(SRC), .DST_BASE(DST), .WORD_COUNT(16'd4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .checksum_o(csum), .bus(bus.master));

   flash_loader #(.SRC_BASE(SRC), .DST_BASE(DST), .WORD_COUNT(16'd0)) dut_z (
      .clk(clk), .rst(rst), .start(start_z), .busy(busy_z), .done(done_z),
      .checksum_o(csum_z), .bus(bus_z.master));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          fdly = 1, rdly = 1;
   bit          fstray = 1'b0, rstray = 1'b0;
   logic [15:0] fmem [8];
   logic [31:0] ram [4];
   int          nwrites = 0;
   logic [31:0] flog [$];
   bit          z_active = 1'b0;
   vec_t        tbl [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef FLASH_LOADER_CHECKSUM_EN
      return s;
`else
      return 32'd0 & s;
`endif
   endfunction

   // Flash/RAM responders: acks are decided on the falling edge for the next rising edge.
   initial begin
      int          fcnt = 0, rcnt = 0;
      logic [31:0] k;
      bus.flash_ack_i = 1'b0; bus.flash_data_i = '0; bus.ram_ack_i = 1'b0;
      bus_z.flash_ack_i = 1'b0; bus_z.flash_data_i = '0; bus_z.ram_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.flash_select_o) begin
            fcnt++;
            if (fcnt >= fdly) begin
               k = (bus.flash_addr_o - SRC) >> 2;
               bus.flash_ack_i  = 1'b1;
               bus.flash_data_i = {16'hDEAD, (k < 8) ? fmem[k[2:0]] : 16'h0};
               flog.push_back(bus.flash_addr_o);
            end else begin
               bus.flash_ack_i = 1'b0;
            end
         end else begin
            fcnt = 0;
            bus.flash_ack_i  = fstray;
            bus.flash_data_i = 32'hDEAD_BEEF;
         end
         if (bus.ram_select_o) begin
            rcnt++;
            if (rcnt >= rdly) begin
               k = (bus.ram_addr_o - DST) >> 2;
               bus.ram_ack_i = 1'b1;
               if (bus.ram_we_o && k < 4) ram[k[1:0]] = bus.ram_data_o;
               nwrites++;
            end else begin
               bus.ram_ack_i = 1'b0;
            end
         end else begin
            rcnt = 0;
            bus.ram_ack_i = rstray;
         end
      end
   end

   always @(negedge clk) begin
      if (busy_z || done_z === 1'bx || bus_z.flash_select_o || bus_z.ram_select_o)
         z_active = 1'b1;
   end

   task automatic load(input int id);
      fdly = tbl[id].fd;
      rdly = tbl[id].rd;
      for (int i = 0; i < 8; i++) fmem[i] = tbl[id].hw[i];
      for (int i = 0; i < 4; i++) ram[i] = 32'hBAD0_0000;
      nwrites = 0;
      flog.delete();
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, done}, 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   initial begin
      logic fs, rs;
      logic [31:0] fa;

      // hw packed with halfword 7 leftmost; w with word 3 leftmost
      tbl[0].fd = 1; tbl[0].rd = 1;
      tbl[0].hw = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
      tbl[0].w  = {32'h8888_7777, 32'h6666_5555, 32'h4444_3333, 32'h2222_1111};
      tbl[0].sum = 32'h5555_1110;
      tbl[1].fd = 3; tbl[1].rd = 2;
      tbl[1].hw = {16'hFFFF, 16'hFFFF, 16'h1234, 16'hABCD, 16'h0001, 16'h8000, 16'hFFFF, 16'h0001};
      tbl[1].w  = {32'hFFFF_FFFF, 32'h1234_ABCD, 32'h0001_8000, 32'hFFFF_0001};
      tbl[1].sum = 32'h1235_2BCD;
      tbl[2].fd = 1; tbl[2].rd = 4;
      tbl[2].hw = {16'h8000, 16'h0000, 16'h2468, 16'h1357, 16'hF0F0, 16'h0F0F, 16'h5A5A, 16'hA5A5};
      tbl[2].w  = {32'h8000_0000, 32'h2468_1357, 32'hF0F0_0F0F, 32'h5A5A_A5A5};
      tbl[2].sum = 32'hEFB2_C80B;

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_fsel", {31'd0, bus.flash_select_o}, 32'd0);
      chk("rst_rsel", {31'd0, bus.ram_select_o}, 32'd0);
      chk("rst_faddr", bus.flash_addr_o, 32'd0);
      chk("rst_csum", csum, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 3; v++) begin
         load(v);
         pulse_start();
         wait_done($sformatf("v%0d_done", v));
         for (int i = 0; i < 4; i++) chk($sformatf("v%0d_ram%0d", v, i), ram[i], tbl[v].w[i]);
         chk($sformatf("v%0d_csum", v), csum, exp_sum(tbl[v].sum));
         chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
         chk($sformatf("v%0d_nwr", v), nwrites, 32'd4);
         chk($sformatf("v%0d_nrd", v), flog.size(), 32'd8);
         @(negedge clk);
      end

      // Slow acks: cycle-exact select/address trace of the first word.
      load(0);
      fdly = 5; rdly = 3;
      pulse_start();
      chk("dly_busy0", {31'd0, busy}, 32'd1);
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         fs = (n >= 1 && n <= 5) || (n >= 7 && n <= 11) || (n == 17);
         rs = (n >= 13 && n <= 15);
         fa = (n <= 5) ? SRC : (n <= 11) ? SRC + 32'd4 : SRC + 32'd8;
         chk($sformatf("dly_fsel%0d", n), {31'd0, bus.flash_select_o}, {31'd0, fs});
         chk($sformatf("dly_faddr%0d", n), bus.flash_addr_o, fs ? fa : 32'd0);
         chk($sformatf("dly_rsel%0d", n), {31'd0, bus.ram_select_o}, {31'd0, rs});
         chk($sformatf("dly_raddr%0d", n), bus.ram_addr_o, rs ? DST : 32'd0);
      end
      wait_done("dly_done");
      chk("dly_ram0", ram[0], 32'h2222_1111);
      chk("dly_ram3", ram[3], 32'h8888_7777);

      // Zero-length copy on the second instance.
      chk("z_done_pre", {31'd0, done_z}, 32'd0);
      @(negedge clk) start_z = 1'b1;
      @(negedge clk) start_z = 1'b0;
      chk("z_done", {31'd0, done_z}, 32'd1);
      repeat (4) @(negedge clk);
      chk("z_done_sticky", {31'd0, done_z}, 32'd1);
      chk("z_csum", csum_z, 32'd0);

      // Reset while reading the high halfword of word 3.
      load(0);
      pulse_start();
      for (int n = 0; n < 200; n++) begin
         if (bus.flash_select_o && bus.flash_addr_o == SRC + 32'h1C) break;
         @(negedge clk);
      end
      chk("ar_reach", bus.flash_addr_o, SRC + 32'h1C);
      #2 rst = 1'b0;
      #1;
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_done", {31'd0, done}, 32'd0);
      chk("ar_fsel", {31'd0, bus.flash_select_o}, 32'd0);
      chk("ar_faddr", bus.flash_addr_o, 32'd0);
      chk("ar_rdata", bus.ram_data_o, 32'd0);
      chk("ar_csum", csum, 32'd0);
      @(negedge clk) rst = 1'b1;
      chk("ar_nwr", nwrites, 32'd3);
      chk("ar_keep2", ram[2], 32'h6666_5555);
      flog.delete();
      nwrites = 0;
      pulse_start();
      wait_done("ar_redone");
      chk("ar_first", flog.size() > 0 ? flog[0] : 32'hFFFF_FFFF, SRC);
      chk("ar_nwr2", nwrites, 32'd4);
      chk("ar_ram3", ram[3], 32'h8888_7777);
      chk("ar_csum2", csum, exp_sum(32'h5555_1110));

      // Start held high with stray acks on both buses.
      load(1);
      fstray = 1'b1; rstray = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      wait_done("hold_done");
      chk("hold_nwr", nwrites, 32'd4);
      chk("hold_ram1", ram[1], 32'h0001_8000);
      chk("hold_ram3", ram[3], 32'hFFFF_FFFF);
      chk("hold_csum", csum, exp_sum(32'h1235_2BCD));
      @(negedge clk);
      chk("hold_idle_busy", {31'd0, busy}, 32'd0);
      chk("hold_idle_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("hold_re_busy", {31'd0, busy}, 32'd1);
      chk("hold_re_done", {31'd0, done}, 32'd0);
      start = 1'b0;
      wait_done("hold_done2");
      chk("hold_nwr2", nwrites, 32'd8);
      chk("hold_restart", flog.size() > 8 ? flog[8] : 32'hFFFF_FFFF, SRC);
      fstray = 1'b0; rstray = 1'b0;

      chk("z_never_active", {31'd0, z_active}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
